// File: rtl/mux_tdm_param_pkg.sv
// Shared constants and helpers for the TDM lane multiplexer.
package mux_tdm_param_pkg;

    // Invalid-slot data policies
    localparam int MODE_ZERO = 0;
    localparam int MODE_HOLD = 1;

    // Ceiling log2, at least 1 so select buses are never zero-width
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) r = r + 1;
        end
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/mux_tdm_param_group.sv
// One output group: picks one of RATIO lanes by sel_now, registers data/valid,
// and counts slots where the picked lane had no valid data.
module mux_tdm_group
    import mux_tdm_param_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int RATIO = 2,
    parameter int MODE  = MODE_ZERO,
    parameter int CNTW  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cnt_clr,
    input  logic [clog2(RATIO)-1:0]     sel_now,
    input  logic [RATIO*WIDTH-1:0]      lane_data,
    input  logic [RATIO-1:0]            lane_valid,
    output logic [WIDTH-1:0]            data,
    output logic                        valid,
    output logic [CNTW-1:0]             cnt
);

    localparam int SELW = clog2(RATIO);

    logic [WIDTH-1:0] pick_data;
    logic             pick_valid;

    // Lane select for the current slot
    always_comb begin
        pick_data  = '0;
        pick_valid = 1'b0;
        for (int i = 0; i < RATIO; i++) begin
            if (sel_now == SELW'(i)) begin
                pick_data  = lane_data[i*WIDTH +: WIDTH];
                pick_valid = lane_valid[i];
            end
        end
    end

    // Output data/valid register with the invalid-slot policy
    always_ff @(posedge clk) begin
        if (reset) begin
            data  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= pick_valid;
            if (pick_valid)
                data <= pick_data;
            else if (MODE == MODE_ZERO)
                data <= '0;
        end
    end

    // Saturating underrun counter; clear beats a same-cycle increment
    always_ff @(posedge clk) begin
        if (reset || cnt_clr)
            cnt <= '0;
        else if (!pick_valid && (cnt != {CNTW{1'b1}}))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/mux_tdm_param.sv
// Time-division mux of NUM_IN lanes onto NUM_IN/RATIO output groups.
// All groups share one slot rotation so they switch in lockstep.
module mux_tdm_param
    import mux_tdm_param_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4,
    parameter int RATIO  = 2,
    parameter int MODE   = MODE_ZERO,
    parameter int CNTW   = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              align,
    input  logic                              cnt_clr,
    input  logic [NUM_IN*WIDTH-1:0]           in_data,
    input  logic [NUM_IN-1:0]                 in_valid,
    output logic [(NUM_IN/RATIO)*WIDTH-1:0]   out_data,
    output logic [NUM_IN/RATIO-1:0]           out_valid,
    output logic [clog2(RATIO)-1:0]           out_slot,
    output logic                              out_first,
    output logic [(NUM_IN/RATIO)*CNTW-1:0]    underrun_cnt
);

    localparam int NUM_OUT = NUM_IN / RATIO;
    localparam int SELW    = clog2(RATIO);

    logic [SELW-1:0] sel;
    logic [SELW-1:0] sel_now;

    // align restarts the rotation from slot 0 in this very cycle
    always_comb begin
        sel_now = align ? '0 : sel;
    end

    // Slot rotation; wraps to 0 with no idle cycle
    always_ff @(posedge clk) begin
        if (reset)
            sel <= '0;
        else if (sel_now == SELW'(RATIO - 1))
            sel <= '0;
        else
            sel <= sel_now + 1'b1;
    end

    // Slot tag that travels alongside the registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            out_slot  <= '0;
            out_first <= 1'b0;
        end else begin
            out_slot  <= sel_now;
            out_first <= (sel_now == '0);
        end
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_grp
        mux_tdm_group #(
            .WIDTH (WIDTH),
            .RATIO (RATIO),
            .MODE  (MODE),
            .CNTW  (CNTW)
        ) u_grp (
            .clk        (clk),
            .reset      (reset),
            .cnt_clr    (cnt_clr),
            .sel_now    (sel_now),
            .lane_data  (in_data[g*RATIO*WIDTH +: RATIO*WIDTH]),
            .lane_valid (in_valid[g*RATIO +: RATIO]),
            .data       (out_data[g*WIDTH +: WIDTH]),
            .valid      (out_valid[g]),
            .cnt        (underrun_cnt[g*CNTW +: CNTW])
        );
    end

endmodule
